// File: rtl/ov7670_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_cfg_sequencer
// Purpose  : Walks a registered configuration ROM of 16-bit {register, value}
//            entries and hands each register write to the SCCB master over a
//            valid/ready handshake. FFFF ends a run, FFFk inserts a delay of
//            (k+1)*DELAY_UNIT cycles, anything else is a register write.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            start, profile       - run request and profile select
//            rom_addr, rom_dout   - {profile, index} address, 1-cycle ROM data
//            cmd_valid/ready,
//            cmd_reg, cmd_data    - register write request to SCCB master
//            busy, done, error    - run status (error = ran out of entries)
//            wr_count             - writes completed in current/last run
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_cfg_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int PROF_W      = 1,
    parameter int DELAY_UNIT  = 1_000_000,
    parameter int MAX_ENTRIES = 2**ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PROF_W-1:0]        profile,
    output logic [PROF_W+ADDR_W-1:0] rom_addr,
    input  logic [15:0]              rom_dout,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_reg,
    output logic [7:0]               cmd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDR_W:0]          wr_count
);

    // Counter must hold the longest delay, 15 * DELAY_UNIT cycles.
    localparam int c_CNT_W = $clog2(15 * DELAY_UNIT + 1);

    localparam logic [ADDR_W:0] c_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_MAX = (ADDR_W+1)'(MAX_ENTRIES);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_FETCH  = 3'd1;
    localparam logic [2:0] c_S_WAIT   = 3'd2;
    localparam logic [2:0] c_S_DECODE = 3'd3;
    localparam logic [2:0] c_S_SEND   = 3'd4;
    localparam logic [2:0] c_S_DELAY  = 3'd5;
    localparam logic [2:0] c_S_DONE   = 3'd6;

    logic [2:0]               r_state;
    logic [PROF_W-1:0]        r_prof;
    logic [ADDR_W:0]          r_index;
    logic [15:0]              r_entry;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [PROF_W+ADDR_W-1:0] r_rom_addr;
    logic                     r_cmd_valid;
    logic [7:0]               r_cmd_reg;
    logic [7:0]               r_cmd_data;
    logic                     r_error;
    logic [ADDR_W:0]          r_wr_count;

    logic [ADDR_W:0]          w_index_nxt;
    logic                     w_at_limit;
    logic                     w_is_end;
    logic                     w_is_delay;
    logic [c_CNT_W-1:0]       w_delay_load;
    logic                     w_accept;
    logic                     w_step;

    assign w_index_nxt  = r_index + c_ONE;
    assign w_at_limit   = (w_index_nxt == c_MAX);
    assign w_is_end     = (r_entry == 16'hFFFF);
    assign w_is_delay   = (r_entry[15:4] == 12'hFFF) && !w_is_end;
    // Loaded with N-1 so that DELAY lasts exactly N cycles counting down to 0.
    assign w_delay_load = c_CNT_W'((32'(r_entry[3:0]) + 32'd1) * 32'(DELAY_UNIT) - 32'd1);
    assign w_accept     = (r_state == c_S_SEND) && cmd_ready;
    // Both a completed write and an expired delay move on to the next entry.
    assign w_step       = w_accept || ((r_state == c_S_DELAY) && (r_cnt == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_prof      <= '0;
            r_index     <= '0;
            r_entry     <= '0;
            r_cnt       <= '0;
            r_rom_addr  <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_reg   <= '0;
            r_cmd_data  <= '0;
            r_error     <= 1'b0;
            r_wr_count  <= '0;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_DONE: begin
                    if (start) begin
                        r_prof     <= profile;
                        r_index    <= '0;
                        r_error    <= 1'b0;
                        r_wr_count <= '0;
                        r_rom_addr <= {profile, {ADDR_W{1'b0}}};
                        r_state    <= c_S_FETCH;
                    end
                end
                c_S_FETCH: r_state <= c_S_WAIT;
                c_S_WAIT: begin
                    r_entry <= rom_dout;
                    r_state <= c_S_DECODE;
                end
                c_S_DECODE: begin
                    if (w_is_end) begin
                        r_state <= c_S_DONE;
                    end else if (w_is_delay) begin
                        r_cnt   <= w_delay_load;
                        r_state <= c_S_DELAY;
                    end else begin
                        r_cmd_reg   <= r_entry[15:8];
                        r_cmd_data  <= r_entry[7:0];
                        r_cmd_valid <= 1'b1;
                        r_state     <= c_S_SEND;
                    end
                end
                c_S_SEND: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_wr_count  <= r_wr_count + c_ONE;
                    end
                end
                c_S_DELAY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase

            // Shared advance for SEND and DELAY; overrides the case above.
            // rom_addr is only updated when a fetch follows, so it holds
            // the last fetched address once the run ends.
            if (w_step) begin
                if (w_at_limit) begin
                    r_error <= 1'b1;
                    r_state <= c_S_DONE;
                end else begin
                    r_index    <= w_index_nxt;
                    r_rom_addr <= {r_prof, w_index_nxt[ADDR_W-1:0]};
                    r_state    <= c_S_FETCH;
                end
            end
        end
    end

    assign rom_addr  = r_rom_addr;
    assign cmd_valid = r_cmd_valid;
    assign cmd_reg   = r_cmd_reg;
    assign cmd_data  = r_cmd_data;
    assign busy      = (r_state != c_S_IDLE) && (r_state != c_S_DONE);
    assign done      = (r_state == c_S_DONE);
    assign error     = r_error;
    assign wr_count  = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_cfg_sequencer
// Purpose  : Scoreboard bench for ov7670_cfg_sequencer. Two instances:
//            A (ADDR_W=3, DELAY_UNIT=4) and B (ADDR_W=2, DELAY_UNIT=5,
//            MAX_ENTRIES=4), each with a behavioural registered ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_cfg_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A
    logic        a_start, a_profile, a_cmd_ready;
    logic [3:0]  a_rom_addr;
    logic [15:0] a_rom_dout;
    logic        a_cmd_valid, a_busy, a_done, a_error;
    logic [7:0]  a_cmd_reg, a_cmd_data;
    logic [3:0]  a_wr_count;
    logic [15:0] a_mem [0:15];

    // Instance B
    logic        b_start, b_profile, b_cmd_ready;
    logic [2:0]  b_rom_addr;
    logic [15:0] b_rom_dout;
    logic        b_cmd_valid, b_busy, b_done, b_error;
    logic [7:0]  b_cmd_reg, b_cmd_data;
    logic [2:0]  b_wr_count;
    logic [15:0] b_mem [0:7];

    always @(posedge clk) a_rom_dout <= a_mem[a_rom_addr];
    always @(posedge clk) b_rom_dout <= b_mem[b_rom_addr];

    ov7670_cfg_sequencer #(.ADDR_W(3), .PROF_W(1), .DELAY_UNIT(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .profile(a_profile),
        .rom_addr(a_rom_addr), .rom_dout(a_rom_dout),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_reg(a_cmd_reg), .cmd_data(a_cmd_data),
        .busy(a_busy), .done(a_done), .error(a_error), .wr_count(a_wr_count)
    );

    ov7670_cfg_sequencer #(.ADDR_W(2), .PROF_W(1), .DELAY_UNIT(5), .MAX_ENTRIES(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .profile(b_profile),
        .rom_addr(b_rom_addr), .rom_dout(b_rom_dout),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_reg(b_cmd_reg), .cmd_data(b_cmd_data),
        .busy(b_busy), .done(b_done), .error(b_error), .wr_count(b_wr_count)
    );

    typedef struct packed {
        logic       inst;
        logic [7:0] r;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   acc_a[$];
    int   acc_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_prof = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    task automatic exp_push(input logic inst, input logic [15:0] rd);
        exp_t e;
        e.inst = inst;
        e.r    = rd[15:8];
        e.d    = rd[7:0];
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic inst, input logic [7:0] r, input logic [7:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: inst=%0d reg=%0h data=%0h, no write expected", inst, r, d);
        end else begin
            e = exp_q.pop_front();
            check("sb_write", {15'd0, inst, r, d}, {15'd0, e.inst, e.r, e.d});
        end
        if (inst) acc_b.push_back(cyc);
        else      acc_a.push_back(cyc);
    endtask

    // Monitor: every handshake that will complete at the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (a_cmd_valid && a_cmd_ready) sb_pop(1'b0, a_cmd_reg, a_cmd_data);
            if (b_cmd_valid && b_cmd_ready) sb_pop(1'b1, b_cmd_reg, b_cmd_data);
            if (chk_prof && a_busy) check("prof1_rom_addr_msb", {31'd0, a_rom_addr[3]}, 32'd1);
        end
    end

    task automatic pulse_start(input logic inst, input logic prof, output int scyc);
        @(posedge clk); #1;
        if (inst) begin b_start = 1'b1; b_profile = prof; end
        else      begin a_start = 1'b1; a_profile = prof; end
        scyc = cyc;
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic wait_done(input logic inst, input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((inst ? b_done : a_done) === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) timeout_fail("wait_done");
    endtask

    task automatic wait_acc(input logic inst, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((inst ? acc_b.size() : acc_a.size()) >= n) break;
            @(posedge clk); #1;
        end
        if ((inst ? acc_b.size() : acc_a.size()) < n) timeout_fail("wait_acc");
    endtask

    task automatic wait_a_valid(input int budget);
        for (int i = 0; i < budget && a_cmd_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (a_cmd_valid !== 1'b1) timeout_fail("wait_a_valid");
    endtask

    task automatic check_end(input logic inst, input string tag, input int wc, input logic err);
        if (inst) begin
            check({tag, "_done"},     {31'd0, b_done},  32'd1);
            check({tag, "_error"},    {31'd0, b_error}, {31'd0, err});
            check({tag, "_wr_count"}, {29'd0, b_wr_count}, 32'(wc));
            check({tag, "_busy"},     {31'd0, b_busy},  32'd0);
        end else begin
            check({tag, "_done"},     {31'd0, a_done},  32'd1);
            check({tag, "_error"},    {31'd0, a_error}, {31'd0, err});
            check({tag, "_wr_count"}, {28'd0, a_wr_count}, 32'(wc));
            check({tag, "_busy"},     {31'd0, a_busy},  32'd0);
        end
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_a_prof0();
        exp_push(1'b0, 16'h1280);
        exp_push(1'b0, 16'h1204);
        exp_push(1'b0, 16'h1180);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, d;

        for (int i = 0; i < 16; i++) a_mem[i] = 16'hFFFF;
        for (int i = 0; i < 8; i++)  b_mem[i] = 16'hFFFF;
        // A profile 0 / profile 1
        a_mem[0] = 16'h1280; a_mem[1] = 16'hFFF0; a_mem[2] = 16'h1204;
        a_mem[3] = 16'h1180; a_mem[4] = 16'hFFFF;
        a_mem[8] = 16'h2211; a_mem[9] = 16'h2322; a_mem[10] = 16'hFFFF;
        // B profile 0: delay FFF3, write FF12, end. Profile 1: no end marker.
        b_mem[0] = 16'hFFF3; b_mem[1] = 16'hFF12; b_mem[2] = 16'hFFFF; b_mem[3] = 16'h0000;
        b_mem[4] = 16'hA1B1; b_mem[5] = 16'hA2B2; b_mem[6] = 16'hA3B3; b_mem[7] = 16'hA4B4;

        rst = 1'b1;
        a_start = 1'b0; a_profile = 1'b0; a_cmd_ready = 1'b1;
        b_start = 1'b0; b_profile = 1'b0; b_cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_outputs", {a_rom_addr, a_cmd_valid, a_cmd_reg, a_cmd_data, a_busy, a_done, a_error, a_wr_count}, 32'd0);
        check("rst_b_outputs", {b_rom_addr, b_cmd_valid, b_cmd_reg, b_cmd_data, b_busy, b_done, b_error, b_wr_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic run with a delay entry between first and second write.
        push_a_prof0();
        acc_a.delete();
        pulse_start(1'b0, 1'b0, s);
        check("busy_rise", {31'd0, a_busy}, 32'd1);
        wait_done(1'b0, 200, d);
        check_end(1'b0, "run_p0", 3, 1'b0);
        check("p0_acc_count", 32'(acc_a.size()), 32'd3);
        if (acc_a.size() == 3) begin
            check("p0_first_write_latency", 32'(acc_a[0] - s), 32'd4);
            check("p0_delay_gap",           32'(acc_a[1] - acc_a[0]), 32'd11);
            check("p0_back_to_back",        32'(acc_a[2] - acc_a[1]), 32'd4);
            check("p0_done_latency",        32'(d - acc_a[2]), 32'd4);
        end

        // Backpressure on the second write.
        push_a_prof0();
        acc_a.delete();
        pulse_start(1'b0, 1'b0, s);
        wait_acc(1'b0, 1, 50);
        a_cmd_ready = 1'b0;
        wait_a_valid(100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", {15'd0, a_cmd_valid, a_cmd_reg, a_cmd_data}, {15'd0, 1'b1, 16'h1204});
        end
        check("stall_wr_count", {28'd0, a_wr_count}, 32'd1);
        @(posedge clk); #1;
        a_cmd_ready = 1'b1;
        wait_done(1'b0, 200, d);
        check_end(1'b0, "run_bp", 3, 1'b0);
        check("bp_acc_count", 32'(acc_a.size()), 32'd3);

        // Profile 1, then a re-run from index 0.
        chk_prof = 1'b1;
        exp_push(1'b0, 16'h2211);
        exp_push(1'b0, 16'h2322);
        pulse_start(1'b0, 1'b1, s);
        check("p1_first_fetch_addr", {28'd0, a_rom_addr}, 32'h8);
        wait_done(1'b0, 200, d);
        check_end(1'b0, "run_p1", 2, 1'b0);
        exp_push(1'b0, 16'h2211);
        exp_push(1'b0, 16'h2322);
        pulse_start(1'b0, 1'b1, s);
        check("rerun_wr_count_clear", {28'd0, a_wr_count}, 32'd0);
        check("rerun_fetch_addr", {28'd0, a_rom_addr}, 32'h8);
        check("rerun_done_clear", {31'd0, a_done}, 32'd0);
        wait_done(1'b0, 200, d);
        check_end(1'b0, "run_p1_again", 2, 1'b0);
        chk_prof = 1'b0;

        // Reset while a write is pending, then replay profile 0.
        a_cmd_ready = 1'b0;
        exp_push(1'b0, 16'h2211);
        pulse_start(1'b0, 1'b1, s);
        wait_a_valid(50);
        @(posedge clk); #1;
        rst = 1'b1;
        check("pre_rst_valid", {31'd0, a_cmd_valid}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_outputs", {a_rom_addr, a_cmd_valid, a_cmd_reg, a_cmd_data, a_busy, a_done, a_error, a_wr_count}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        acc_a.delete();
        a_cmd_ready = 1'b1;
        push_a_prof0();
        pulse_start(1'b0, 1'b0, s);
        wait_done(1'b0, 200, d);
        check_end(1'b0, "replay", 3, 1'b0);

        // B: delay scaling and FF12 treated as a write.
        acc_b.delete();
        exp_push(1'b1, 16'hFF12);
        pulse_start(1'b1, 1'b0, s);
        wait_done(1'b1, 200, d);
        check_end(1'b1, "b_delay", 1, 1'b0);
        check("b_delay_acc_count", 32'(acc_b.size()), 32'd1);
        if (acc_b.size() == 1)
            check("b_delay_latency", 32'(acc_b[0] - s), 32'd27);

        // B: no end marker, limit of 4 entries; a start while busy is ignored.
        acc_b.delete();
        exp_push(1'b1, 16'hA1B1);
        exp_push(1'b1, 16'hA2B2);
        exp_push(1'b1, 16'hA3B3);
        exp_push(1'b1, 16'hA4B4);
        pulse_start(1'b1, 1'b1, s);
        wait_acc(1'b1, 1, 50);
        pulse_start(1'b1, 1'b0, d);
        wait_done(1'b1, 200, d);
        check_end(1'b1, "b_limit", 4, 1'b1);
        check("b_limit_acc_count", 32'(acc_b.size()), 32'd4);
        if (acc_b.size() == 4)
            check("b_limit_done_latency", 32'(d - acc_b[3]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ov7670_cfg_sequencer.md
# ov7670_cfg_sequencer

Parametrised configuration sequencer for the OV7670 camera path. It walks a registered configuration ROM of 16-bit {register, value} entries and issues each register write to the downstream SCCB master over a valid/ready handshake. It interprets in-ROM delay and end markers, supports several selectable configuration profiles and re-runs on request. It sits between the configuration ROM and the SCCB master, under control of the top-level camera controller.

## Interface
Parameters:
- `ADDR_W`, 8: ROM entry index width within one profile.
- `PROF_W`, 1: profile-select width; ROM address is {profile, index}, `PROF_W+ADDR_W` bits.
- `DELAY_UNIT`, 1_000_000: clk cycles per delay unit, ≥1.
- `MAX_ENTRIES`, 2**ADDR_W: index limit; reaching it without an end marker is an error.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a sequence when idle or done.
- `profile`  in  PROF_W  profile select, sampled on accepted `start`.
- `rom_addr`  out  PROF_W+ADDR_W  ROM address.
- `rom_dout`  in  16  ROM data, valid one cycle after `rom_addr` (registered ROM).
- `cmd_valid`  out  1  write request to SCCB master.
- `cmd_ready`  in  1  SCCB master accepts request.
- `cmd_reg`  out  8  register address = entry[15:8].
- `cmd_data`  out  8  register value = entry[7:0].
- `busy`  out  1  sequence in progress.
- `done`  out  1  sequence finished; held until next `start` or reset.
- `error`  out  1  finished by hitting `MAX_ENTRIES`; held with `done`.
- `wr_count`  out  ADDR_W+1  register writes completed in current/last run.

## Operation
- Entry decode: 16'hFFFF = end; 16'hFFFk, k=0..14 = delay of (k+1)·DELAY_UNIT cycles; any other entry (including reg 8'hFF with a non-Fx value) = register write.
- States: IDLE, FETCH, WAIT, DECODE, SEND, DELAY, DONE.
- IDLE/DONE: `start` → latch `profile`, index←0, clear `done`, `error`, `wr_count` → FETCH. `start` ignored in all other states.
- FETCH: drive `rom_addr`={prof, index} → WAIT.
- WAIT: one cycle of ROM latency; the entry is captured into an internal register at the end of this cycle → DECODE.
- DECODE: end → DONE; delay → load counter with (k+1)·DELAY_UNIT−1 → DELAY; write → SEND.
- SEND: `cmd_valid`=1 with `cmd_reg`/`cmd_data` stable until the handshake. On `cmd_valid && cmd_ready`: `wr_count`+1, index+1 → FETCH, or → DONE with `error`=1 if index+1 == MAX_ENTRIES.
- DELAY: decrement to 0. At 0: index+1 → FETCH, with the same MAX_ENTRIES check.
- Counter width is sized for 15·DELAY_UNIT. All index arithmetic is ADDR_W+1 bits, so there is no wrap.
- `rom_addr` holds its last value outside FETCH/WAIT.

## Timing
- Reset values: `rom_addr`=0, `cmd_valid`=0, `cmd_reg`=0, `cmd_data`=0, `busy`=0, `done`=0, `error`=0, `wr_count`=0; state IDLE.
- `busy`=1 in every state except IDLE/DONE. `busy` rises the cycle after `start`.
- Write entry: `cmd_valid` asserts 3 cycles after FETCH is entered. With `cmd_ready` held high, one write completes every 4 cycles.
- Delay entry FFFk: (k+1)·DELAY_UNIT cycles in DELAY, plus 3 cycles of fetch/decode overhead.
- `done` rises the cycle after DECODE sees FFFF, or the cycle after the final SEND/DELAY that reaches the limit.
- `cmd_ready` while `cmd_valid`=0: ignored.
- `rst` mid-sequence: next cycle all outputs return to reset values. This includes dropping `cmd_valid` even if the SCCB master is busy; the master must tolerate this.
- `start` during busy: no effect. `start` in the same cycle as `rst`: reset wins.

## Test plan
- Profile 0 ROM = {1280, FFF0, 1204, 1180, FFFF}, DELAY_UNIT=4, `cmd_ready`=1 → writes in order (12,80), (12,04), (11,80); 4-cycle delay gap after the first write; `done`=1, `error`=0, `wr_count`=3.
- Backpressure: `cmd_ready` low for 10 cycles on the 2nd write → `cmd_valid`, `cmd_reg`, `cmd_data` stable for all 10 cycles; exactly one acceptance; `wr_count` increments once.
- Delay scaling: entry FFF3, DELAY_UNIT=5 → exactly 20 cycles in DELAY; entry FF12 → issued as write (FF,12).
- No end marker, MAX_ENTRIES=4, all write entries → 4 writes, then `done`=1, `error`=1.
- `profile`=1 → `rom_addr` MSB=1 on every fetch; a second `start` after `done` re-runs from index 0 with `wr_count` cleared.
- `rst` asserted while `cmd_valid`=1 mid-run → next cycle all outputs at reset values; a fresh `start` replays from entry 0.
